// File: rtl/al422_pkg.sv
// Shared encodings and widths for the AL422B frame controller.
package al422_pkg;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_ARM     = 2'd1,
    C_WRST    = 2'd2,
    C_CAPTURE = 2'd3
  } cap_state_t;

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_HIGH = 3'd1,
    R_LOW  = 3'd2,
    R_DONE = 3'd3,
    R_RST  = 3'd4
  } rd_state_t;

  localparam int WRST_CLKS  = 2;
  localparam int WRST_CNT_W = 2;
  localparam int LINE_CNT_W = 10;
  localparam int BYTE_CNT_W = 19;

endpackage

// File: rtl/al422_rdclk_gen.sv
// AL422 read-clock generator: half-period counter with phase-end strobe.
// rdclk is high during the first half of each period while run is held.
module al422_rdclk_gen #(
  parameter int RDCLK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic rdclk,
  output logic phase_end,
  output logic low_phase
);

  localparam int CNT_W = $clog2(RDCLK_HALF) + 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             half_reg;

  assign phase_end = run && (cnt_reg == CNT_W'(RDCLK_HALF - 1));
  assign rdclk     = run && !half_reg;
  assign low_phase = half_reg;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_reg  <= '0;
      half_reg <= 1'b0;
    end else if (phase_end) begin
      cnt_reg  <= '0;
      half_reg <= ~half_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/al422_frame_ctrl.sv
// OV7670 -> AL422B frame capture and byte-wise readback controller.
// Optional frame statistics outputs enabled by AL422_FRAME_STATS_EN.
module al422_frame_ctrl
  import al422_pkg::*;
#(
  parameter int RDCLK_HALF = 4,
  parameter int RST_CLKS   = 4,
  parameter int VSYNC_POL  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] din,
  input  logic       take_picture,
  input  logic       rd_req,
  input  logic       reset_wr,
  input  logic       reset_rd,
  output logic       we,
  output logic       wrst,
  output logic       rrst,
  output logic       oe,
  output logic       rdclk,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       cap_busy,
  output logic       rd_busy,
  output logic       frame_done
`ifdef AL422_FRAME_STATS_EN
  ,
  output logic [LINE_CNT_W-1:0] line_cnt,
  output logic [BYTE_CNT_W-1:0] byte_cnt
`endif
);

  localparam int RST_CNT_W = $clog2(RST_CLKS) + 1;

  logic vs_meta_reg, vs_sync_reg, vs_prev_reg;
  logic vs_norm, frame_edge;

  cap_state_t            cap_state_reg, cap_state_next;
  logic [WRST_CNT_W-1:0] wrst_cnt_reg, mwrst_cnt_reg;
  logic                  frame_done_reg;

  rd_state_t             rd_state_reg, rd_state_next;
  logic [RST_CNT_W-1:0]  rst_cnt_reg;
  logic [7:0]            dout_reg;
  logic                  gen_run, phase_end, low_phase;

  // Edge detection runs on the polarity-normalised vsync.
  assign vs_norm    = (VSYNC_POL != 0) ? vs_sync_reg : ~vs_sync_reg;
  assign frame_edge = vs_norm && !vs_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
    end else begin
      vs_meta_reg <= vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_norm;
    end
  end

  always_comb begin
    cap_state_next = cap_state_reg;
    we             = 1'b0;
    wrst           = (mwrst_cnt_reg == '0);
    cap_busy       = (cap_state_reg != C_IDLE);
    case (cap_state_reg)
      C_IDLE:    if (take_picture) cap_state_next = C_ARM;
      C_ARM:     if (frame_edge) cap_state_next = C_WRST;
      C_WRST: begin
        wrst = 1'b0;
        if (wrst_cnt_reg == WRST_CNT_W'(WRST_CLKS - 1)) cap_state_next = C_CAPTURE;
      end
      C_CAPTURE: begin
        we = 1'b1;
        if (frame_edge) cap_state_next = C_IDLE;
      end
      default:   cap_state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state_reg  <= C_IDLE;
      wrst_cnt_reg   <= '0;
      mwrst_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      cap_state_reg <= cap_state_next;
      wrst_cnt_reg  <= (cap_state_reg == C_WRST) ? wrst_cnt_reg + 1'b1 : '0;
      // Manual write-pointer reset only runs while the capture path is idle.
      if (cap_state_reg != C_IDLE)
        mwrst_cnt_reg <= '0;
      else if (mwrst_cnt_reg != '0)
        mwrst_cnt_reg <= mwrst_cnt_reg - 1'b1;
      else if (reset_wr && !take_picture)
        mwrst_cnt_reg <= WRST_CNT_W'(WRST_CLKS);
      if (cap_state_reg == C_IDLE && take_picture)
        frame_done_reg <= 1'b0;
      else if (cap_state_reg == C_CAPTURE && frame_edge)
        frame_done_reg <= 1'b1;
    end
  end

  assign frame_done = frame_done_reg;

  assign gen_run = (rd_state_reg == R_HIGH) || (rd_state_reg == R_LOW) ||
                   (rd_state_reg == R_RST);

  al422_rdclk_gen #(
    .RDCLK_HALF(RDCLK_HALF)
  ) u_rdclk_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (gen_run),
    .rdclk    (rdclk),
    .phase_end(phase_end),
    .low_phase(low_phase)
  );

  always_comb begin
    rd_state_next = rd_state_reg;
    oe            = 1'b1;
    rrst          = 1'b1;
    dout_valid    = 1'b0;
    rd_busy       = (rd_state_reg != R_IDLE);
    case (rd_state_reg)
      R_IDLE: begin
        if (reset_rd)    rd_state_next = R_RST;
        else if (rd_req) rd_state_next = R_HIGH;
      end
      R_HIGH: begin
        oe = 1'b0;
        if (phase_end) rd_state_next = R_LOW;
      end
      R_LOW: begin
        oe = 1'b0;
        if (phase_end) rd_state_next = R_DONE;
      end
      R_DONE: begin
        dout_valid    = 1'b1;
        rd_state_next = R_IDLE;
      end
      R_RST: begin
        rrst = 1'b0;
        // A period completes at the end of its low half.
        if (phase_end && low_phase && rst_cnt_reg == RST_CNT_W'(RST_CLKS - 1))
          rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      rst_cnt_reg  <= '0;
      dout_reg     <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (rd_state_reg != R_RST)
        rst_cnt_reg <= '0;
      else if (phase_end && low_phase)
        rst_cnt_reg <= rst_cnt_reg + 1'b1;
      if (rd_state_reg == R_HIGH && phase_end)
        dout_reg <= din;
    end
  end

  assign dout = dout_reg;

`ifdef AL422_FRAME_STATS_EN
  logic                  hs_meta_reg, hs_sync_reg, hs_prev_reg;
  logic [LINE_CNT_W-1:0] line_cnt_reg;
  logic [BYTE_CNT_W-1:0] byte_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_meta_reg  <= 1'b0;
      hs_sync_reg  <= 1'b0;
      hs_prev_reg  <= 1'b0;
      line_cnt_reg <= '0;
      byte_cnt_reg <= '0;
    end else begin
      hs_meta_reg <= href;
      hs_sync_reg <= hs_meta_reg;
      hs_prev_reg <= hs_sync_reg;
      if (cap_state_next == C_WRST && cap_state_reg != C_WRST)
        line_cnt_reg <= '0;
      else if (cap_state_reg == C_CAPTURE && hs_sync_reg && !hs_prev_reg &&
               line_cnt_reg != '1)
        line_cnt_reg <= line_cnt_reg + 1'b1;
      if (rd_state_reg == R_RST && rd_state_next == R_IDLE)
        byte_cnt_reg <= '0;
      else if (dout_valid && byte_cnt_reg != '1)
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
    end
  end

  assign line_cnt = line_cnt_reg;
  assign byte_cnt = byte_cnt_reg;
`else
  logic unused_href;
  assign unused_href = href;
`endif

endmodule

// File: tb/tb_al422_frame_ctrl.sv
// Directed self-checking bench for al422_frame_ctrl (default parameters).
// Define AL422_FRAME_STATS_EN to also exercise the statistics counters.
module tb_al422_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst, vsync, href, take_picture, rd_req, reset_wr, reset_rd;
  logic [7:0] din;
  logic       we, wrst, rrst, oe, rdclk, dout_valid, cap_busy, rd_busy, frame_done;
  logic [7:0] dout;
`ifdef AL422_FRAME_STATS_EN
  logic [9:0]  line_cnt;
  logic [18:0] byte_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  al422_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .href        (href),
    .din         (din),
    .take_picture(take_picture),
    .rd_req      (rd_req),
    .reset_wr    (reset_wr),
    .reset_rd    (reset_rd),
    .we          (we),
    .wrst        (wrst),
    .rrst        (rrst),
    .oe          (oe),
    .rdclk       (rdclk),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .cap_busy    (cap_busy),
    .rd_busy     (rd_busy),
    .frame_done  (frame_done)
`ifdef AL422_FRAME_STATS_EN
    ,
    .line_cnt    (line_cnt),
    .byte_cnt    (byte_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00;
    take_picture = 1'b0; rd_req = 1'b0; reset_wr = 1'b0; reset_rd = 1'b0;

    // Reset held for 3 clocks with vsync toggling.
    for (int i = 0; i < 3; i++) begin
      vsync = ~vsync;
      tick();
      chk1("rst_we", we, 1'b0);
      chk1("rst_wrst", wrst, 1'b1);
      chk1("rst_rrst", rrst, 1'b1);
      chk1("rst_oe", oe, 1'b1);
      chk1("rst_rdclk", rdclk, 1'b0);
      chkn("rst_dout", 32'(dout), 32'h0);
      chk1("rst_dvalid", dout_valid, 1'b0);
      chk1("rst_capbusy", cap_busy, 1'b0);
      chk1("rst_rdbusy", rd_busy, 1'b0);
      chk1("rst_fdone", frame_done, 1'b0);
    end
    rst = 1'b0; vsync = 1'b0;
    repeat (4) tick();

    // Capture one frame.
    take_picture = 1'b1; tick(); take_picture = 1'b0;
    chk1("arm_busy", cap_busy, 1'b1);
    chk1("arm_fdone", frame_done, 1'b0);
    repeat (3) tick();
    chk1("arm_we", we, 1'b0);
    vsync = 1'b1;
    tick(); chk1("edge0_p1_wrst", wrst, 1'b1);
    tick(); chk1("edge0_p2_wrst", wrst, 1'b1);
    tick(); chk1("edge0_p3_wrst", wrst, 1'b0); chk1("edge0_p3_we", we, 1'b0);
    tick(); chk1("edge0_p4_wrst", wrst, 1'b0); chk1("edge0_p4_we", we, 1'b0);
    tick(); chk1("edge0_p5_wrst", wrst, 1'b1); chk1("edge0_p5_we", we, 1'b1);
    vsync = 1'b0;
    repeat (5) tick();
    chk1("cap_we", we, 1'b1);
    take_picture = 1'b1; tick(); take_picture = 1'b0;
    chk1("ign_take_we", we, 1'b1);
    repeat (3) tick();
    chk1("ign_take_we2", we, 1'b1);
    chk1("cap_fdone", frame_done, 1'b0);
    vsync = 1'b1;
    tick(); chk1("edge1_p1_we", we, 1'b1);
    tick(); chk1("edge1_p2_we", we, 1'b1); chk1("edge1_p2_fdone", frame_done, 1'b0);
    tick(); chk1("edge1_p3_we", we, 1'b0); chk1("edge1_p3_fdone", frame_done, 1'b1);
    chk1("edge1_p3_busy", cap_busy, 1'b0);
    vsync = 1'b0;
    repeat (5) tick();
    chk1("fdone_sticky", frame_done, 1'b1);

    // Manual write-pointer reset while idle.
    reset_wr = 1'b1; tick(); reset_wr = 1'b0;
    chk1("mwrst_c1", wrst, 1'b0); chk1("mwrst_we", we, 1'b0);
    tick(); chk1("mwrst_c2", wrst, 1'b0);
    tick(); chk1("mwrst_c3", wrst, 1'b1);

    // Single byte read.
    din = 8'hA5; rd_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) rd_req = 1'b0;
      chk1($sformatf("rd_rdclk_%0d", i), rdclk, (i <= 4));
      chk1($sformatf("rd_oe_%0d", i), oe, (i > 8));
      chk1($sformatf("rd_dvalid_%0d", i), dout_valid, (i == 9));
      chk1($sformatf("rd_busy_%0d", i), rd_busy, (i <= 9));
      if (i == 4) chkn("rd_dout_pre", 32'(dout), 32'h00);
      if (i == 5) begin
        chkn("rd_dout_latch", 32'(dout), 32'hA5);
        din = 8'h3C;
      end
      if (i == 9) chkn("rd_dout_valid", 32'(dout), 32'hA5);
    end

    // Read reset and read request together; reset wins, later request ignored.
    reset_rd = 1'b1; rd_req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin reset_rd = 1'b0; rd_req = 1'b0; end
      if (i == 5) rd_req = 1'b1;
      if (i == 6) rd_req = 1'b0;
      chk1($sformatf("rrst_dvalid_%0d", i), dout_valid, 1'b0);
      if (i <= 32) begin
        chk1($sformatf("rrst_lvl_%0d", i), rrst, 1'b0);
        chk1($sformatf("rrst_rdclk_%0d", i), rdclk, (((i - 1) % 8) < 4));
        chk1($sformatf("rrst_busy_%0d", i), rd_busy, 1'b1);
      end else begin
        chk1($sformatf("rrst_rel_%0d", i), rrst, 1'b1);
        chk1($sformatf("rrst_idle_%0d", i), rd_busy, 1'b0);
        chk1($sformatf("rrst_oe_%0d", i), oe, 1'b1);
      end
    end
    chkn("rrst_dout_hold", 32'(dout), 32'hA5);

    // Reset during capture and read aborts both.
    take_picture = 1'b1; tick(); take_picture = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (5) tick();
    chk1("abort_we_pre", we, 1'b1);
    chk1("abort_fdone_clr", frame_done, 1'b0);
    take_picture = 1'b1; tick(); take_picture = 1'b0;
    chk1("abort_ign_take", we, 1'b1);
    chk1("abort_busy_pre", cap_busy, 1'b1);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk1("abort_rdbusy_pre", rd_busy, 1'b1);
    rst = 1'b1; tick();
    chk1("abort_we", we, 1'b0);
    chk1("abort_capbusy", cap_busy, 1'b0);
    chk1("abort_rdbusy", rd_busy, 1'b0);
    chk1("abort_oe", oe, 1'b1);
    chk1("abort_rdclk", rdclk, 1'b0);
    rst = 1'b0; vsync = 1'b0;
    repeat (4) tick();

`ifdef AL422_FRAME_STATS_EN
    // 480 lines in one frame, then three reads.
    take_picture = 1'b1; tick(); take_picture = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (5) tick();
    chk1("st_we", we, 1'b1);
    chkn("st_line_clr", 32'(line_cnt), 32'd0);
    vsync = 1'b0;
    for (int l = 0; l < 480; l++) begin
      href = 1'b1; tick(); tick();
      href = 1'b0; tick(); tick();
    end
    repeat (3) tick();
    vsync = 1'b1;
    repeat (4) tick();
    chk1("st_we_end", we, 1'b0);
    chkn("st_line_cnt", 32'(line_cnt), 32'd480);
    vsync = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      repeat (10) tick();
    end
    chkn("st_byte_cnt", 32'(byte_cnt), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/al422_frame_ctrl.md
Name: al422_frame_ctrl

Overview:
- Controller between the OV7670 camera sensor, the AL422B frame FIFO and the Wishbone camera register block.
- Captures exactly one frame into the FIFO per take-picture command, gated by VSYNC.
- Reads the FIFO back one byte per software read request and generates the FIFO read clock, reset and output-enable strobes.
- Reports per-read valid and busy/done status to the register block.

Parameters:
- RDCLK_HALF, 4: clk cycles per half-period of rdclk (minimum 1).
- RST_CLKS, 4: number of rdclk periods rrst is held low during a read reset.
- VSYNC_POL, 1: 1 = VSYNC active-high frame marker; 0 = active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- vsync  in  1  camera VSYNC, asynchronous
- href  in  1  camera HREF, asynchronous
- din  in  8  AL422 data output
- take_picture  in  1  single-cycle pulse: capture next full frame
- rd_req  in  1  single-cycle pulse: fetch next byte
- reset_wr  in  1  single-cycle pulse: reset FIFO write pointer
- reset_rd  in  1  single-cycle pulse: reset FIFO read pointer
- we  out  1  AL422 write enable, active-high
- wrst  out  1  AL422 write reset, active-low
- rrst  out  1  AL422 read reset, active-low
- oe  out  1  AL422 output enable, active-low
- rdclk  out  1  AL422 read clock
- dout  out  8  last byte read
- dout_valid  out  1  one-cycle pulse, dout updated
- cap_busy  out  1  capture in progress (ARM..CAPTURE)
- rd_busy  out  1  read or read-reset in progress
- frame_done  out  1  sticky; set at end of capture, cleared by take_picture

Behaviour:
- Reset: we=0, wrst=1, rrst=1, oe=1, rdclk=0, dout=0, dout_valid=0, cap_busy=0, rd_busy=0, frame_done=0. Both FSMs go to IDLE. Any operation in flight at reset is aborted.
- Input synchronisation:
  - vsync and href pass through 2-flop synchronisers.
  - vsync is normalised by VSYNC_POL.
  - A frame edge is the rising edge of the normalised, synchronised vsync.
- Capture FSM states:
  - C_IDLE: on take_picture, clear frame_done and go to C_ARM.
  - C_ARM: wait for a frame edge, then go to C_WRST.
  - C_WRST: drive wrst=0 for 2 clk, then go to C_CAPTURE.
  - C_CAPTURE: we=1 until the next frame edge. On that edge, set we=0 and frame_done=1 in the same cycle, then return to C_IDLE.
- cap_busy=1 in every capture state except C_IDLE.
- A take_picture pulse while not in C_IDLE is ignored.
- reset_wr pulse while in C_IDLE drives wrst=0 for 2 clk with we=0. A reset_wr pulse in any other capture state is ignored.
- Read FSM states:
  - R_IDLE: rdclk=0.
  - rd_req in R_IDLE: go to R_HIGH and set oe=0. oe stays 0 until the read completes.
  - R_HIGH: rdclk=1 for RDCLK_HALF clk. On the last cycle, latch din into dout. Then go to R_LOW.
  - R_LOW: rdclk=0 for RDCLK_HALF clk. Then go to R_DONE.
  - R_DONE: dout_valid=1 for 1 cycle, oe=1, then return to R_IDLE.
  - Latency from rd_req to dout_valid: 2*RDCLK_HALF+1 cycles; 9 with defaults.
- Read reset:
  - reset_rd in R_IDLE: go to R_RST. rrst=0 while rdclk toggles for RST_CLKS full periods, then rrst=1 and return to R_IDLE.
  - No dout_valid is generated during R_RST.
- rd_busy=1 in every read state except R_IDLE.
- Simultaneous reset_rd and rd_req in R_IDLE: reset_rd wins and rd_req is dropped.
- rd_req or reset_rd while rd_busy is ignored and not queued.
- The read and capture paths are independent; reading during capture is legal.
- href has no effect on we; WEN gating by HREF is done on the camera board.
- Half-period counter width: clog2(RDCLK_HALF)+1. The counter wraps to 0 on each phase change.

Optional Feature:
- Macro: AL422_FRAME_STATS_EN.
- When defined, the block adds two outputs:
  - line_cnt[9:0]: counts synchronised href rising edges during C_CAPTURE. Cleared on entry to C_WRST; holds its value after capture. Saturates at 1023.
  - byte_cnt[18:0]: counts dout_valid pulses. Cleared by reset_rd completion. Saturates at all-ones.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package al422_pkg holds:
  - capture and read state encodings;
  - the localparam for the wrst pulse length (2);
  - the line and byte counter widths.
- One natural sub-module, al422_rdclk_gen: the half-period counter plus the rdclk/phase-end strobes. It is shared by the R_HIGH/R_LOW read path and the R_RST path.

Test Plan:
- rst high for 3 clk, with vsync toggling -> all outputs hold their reset values and cap_busy=0.
- take_picture, then frame edges at t0 and t1 -> wrst=0 for exactly 2 clk after t0+sync delay; we=1 from t0+4 until the t1 edge cycle; frame_done=1 from t1 onward.
- din=8'hA5 and rd_req with RDCLK_HALF=4 -> rdclk high 4 clk then low 4 clk; dout=8'hA5 and dout_valid pulse 9 cycles after rd_req; oe low throughout the read.
- reset_rd and rd_req in the same cycle -> rrst=0 for 4 rdclk periods, no dout_valid; a second rd_req during R_RST is ignored.
- take_picture during C_CAPTURE, then rst asserted mid-capture -> the second take_picture is ignored; after rst, we=0 and cap_busy=0 within 1 cycle.
- With AL422_FRAME_STATS_EN defined, 480 href pulses inside one capture -> line_cnt=480; 3 reads -> byte_cnt=3.
